mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter : shares one memory port between fetch and load/store,
//                    data first, stalling the pipeline until both are served.
// Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int               CNT_W   = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_VAL = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT_I = 2'd1,
        ST_WAIT_D = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             if_srv;
    logic             d_srv;
    logic             d_is_wr;
    logic             d_req;
    logic             if_pend;
    logic             d_pend;

    assign d_req   = d_read | d_write;
    assign if_pend = if_req & ~if_srv;
    assign d_pend  = d_req & ~d_srv;
    assign stall   = rst_n & (if_pend | d_pend);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            if_srv    <= 1'b0;
            d_srv     <= 1'b0;
            d_is_wr   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Both d_read and d_write high resolves to a write.
                    if (d_pend) begin
                        state     <= ST_WAIT_D;
                        mem_en    <= 1'b1;
                        mem_we    <= d_write;
                        d_is_wr   <= d_write;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        cnt       <= LAT_VAL;
                    end else if (if_pend) begin
                        state    <= ST_WAIT_I;
                        mem_en   <= 1'b1;
                        mem_addr <= if_addr;
                        cnt      <= LAT_VAL;
                    end
                end
                ST_WAIT_I, ST_WAIT_D: begin
                    if (cnt == '0) begin
                        if (state == ST_WAIT_I) begin
                            if_rdata <= mem_rdata;
                            if_srv   <= 1'b1;
                        end else begin
                            if (!d_is_wr) begin
                                d_rdata <= mem_rdata;
                            end
                            d_srv <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // The pipeline advances on this edge; start a fresh stall window.
            if (!stall) begin
                if_srv <= 1'b0;
                d_srv  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
